// File: rtl/parity_frame_controller.sv
// parity_frame_controller
//   Serial front-end for the even-parity check datapath. Collects a framed
//   serial stream (start bit '1', DATA_BITS data bits first-to-last, one
//   even-parity bit), presents the assembled word with a pass/fail flag over
//   a valid/ready handshake, and keeps a saturating count of failed frames.
//
// Ports
//   clk           in   system clock, rising edge
//   reset_n       in   synchronous active-low reset
//   in_valid      in   in_bit is valid this cycle
//   in_bit        in   serial frame bit
//   in_ready      out  a bit is accepted on in_valid & in_ready
//   out_valid     out  completed frame available (held until out_ready)
//   out_ready     in   consumer takes the frame
//   out_data      out  assembled word, first data bit received is the MSB
//   out_parity_ok out  1 = XOR of data and parity bits is 0
//   err_count     out  saturating count of frames that failed the check
//   clr_err       in   synchronous clear of err_count (wins over increment)
//   busy          out  controller is not idle

module parity_frame_controller #(
  parameter int unsigned DATA_BITS = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_parity_ok,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    HOLD
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [CW-1:0]        bit_cnt;
  logic                 run_par;
  logic                 accept;
  logic                 last_data;
  logic                 par_fail;

  assign in_ready  = (state != HOLD);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign last_data = (bit_cnt == CW'(DATA_BITS - 1));
  // Evaluated on the parity-bit cycle: running parity plus the parity bit.
  assign par_fail  = run_par ^ in_bit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && in_bit)    state_nxt = DATA;
      DATA:    if (accept && last_data) state_nxt = PARITY;
      PARITY:  if (accept)              state_nxt = HOLD;
      HOLD:    if (out_ready)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      run_par       <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_parity_ok <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && in_bit) begin
            shreg   <= '0;
            bit_cnt <= '0;
            run_par <= 1'b0;
          end
        end
        DATA: begin
          if (accept) begin
            shreg   <= (shreg << 1) | DATA_BITS'(in_bit);
            run_par <= run_par ^ in_bit;
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        PARITY: begin
          if (accept) begin
            out_data      <= shreg;
            out_parity_ok <= ~par_fail;
            out_valid     <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (state == PARITY && accept && par_fail && err_count != '1) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_frame_controller.sv
// Bench for parity_frame_controller: two instances share all stimulus, one
// with an 8-bit and one with a 2-bit error counter, so saturation is visible
// while the wide counter tracks the total.

module tb_parity_frame_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic       clr_err;

  logic       in_ready, out_valid, out_parity_ok, busy;
  logic [3:0] out_data;
  logic [7:0] err_count;

  logic       in_ready2, out_valid2, out_parity_ok2, busy2;
  logic [3:0] out_data2;
  logic [1:0] err_count2;

  always #5 clk = ~clk;

  parity_frame_controller #(.DATA_BITS(4), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_parity_ok(out_parity_ok),
    .err_count(err_count), .clr_err(clr_err), .busy(busy)
  );

  parity_frame_controller #(.DATA_BITS(4), .ERR_CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_parity_ok(out_parity_ok2),
    .err_count(err_count2), .clr_err(clr_err), .busy(busy2)
  );

  typedef struct {
    logic [3:0] d;
    logic       ok;
    logic [7:0] e8;
    logic [1:0] e2;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_e8 = '0;
  logic [1:0] m_e2 = '0;
  logic       pv = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int unsigned gap);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expectation is pushed just before the parity bit is driven.
  task automatic send_frame(input logic [3:0] d, input logic p,
                            input int unsigned gap, input logic clr);
    exp_t e;
    logic bad;
    bad = (^d) ^ p;
    send_bit(1'b1, gap);
    for (int i = 3; i >= 0; i--) send_bit(d[i], gap);
    if (clr) begin
      m_e8 = '0;
      m_e2 = '0;
    end else if (bad) begin
      if (m_e8 != 8'hff) m_e8 = m_e8 + 8'd1;
      if (m_e2 != 2'b11) m_e2 = m_e2 + 2'd1;
    end
    e.d  = d;
    e.ok = ~bad;
    e.e8 = m_e8;
    e.e2 = m_e2;
    sb.push_back(e);
    clr_err = clr;
    send_bit(p, 0);
    clr_err = 1'b0;
  endtask

  // Each rising edge of out_valid is one completed frame.
  always @(negedge clk) begin
    if (!reset_n) begin
      pv = 1'b0;
    end else begin
      if (out_valid && !pv) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("sb_data", 32'(out_data), 32'(mon_e.d));
          check("sb_ok", 32'(out_parity_ok), 32'(mon_e.ok));
          check("sb_err8", 32'(err_count), 32'(mon_e.e8));
          check("sb_err2", 32'(err_count2), 32'(mon_e.e2));
          check("sb_data2", 32'(out_data2), 32'(mon_e.d));
          check("sb_ok2", 32'(out_parity_ok2), 32'(mon_e.ok));
        end
      end
      pv = out_valid;
    end
  end

  initial begin
    logic [1:0] sat_exp [4];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3};
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ok", 32'(out_parity_ok), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);

    // Good frame: start, 1011, parity 1.
    send_frame(4'b1011, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("good_valid_hi", 32'(out_valid), 32'd1);
    check("good_data", 32'(out_data), 32'hb);
    check("good_ok", 32'(out_parity_ok), 32'd1);
    check("good_in_ready_hold", 32'(in_ready), 32'd0);
    check("good_err", 32'(err_count), 32'd0);
    @(negedge clk);
    check("good_valid_lo", 32'(out_valid), 32'd0);
    check("good_in_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Exhaustive nibbles: correct parity, then inverted parity.
    for (int unsigned v = 0; v < 16; v++) begin
      send_frame(v[3:0], ^v[3:0], 0, 1'b0);
      idle(2);
    end
    for (int unsigned v = 0; v < 16; v++) begin
      send_frame(v[3:0], ~(^v[3:0]), 0, 1'b0);
      idle(2);
    end
    check("exh_err16", 32'(err_count), 32'd16);

    // Idle zeros, then a frame with gaps between every bit and bad parity.
    in_valid = 1'b1;
    in_bit   = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    send_frame(4'b0001, 1'b0, 1, 1'b0);
    idle(2);
    check("gap_data_kept", 32'(out_data), 32'h1);
    check("gap_ok_kept", 32'(out_parity_ok), 32'd0);
    check("gap_err", 32'(err_count), 32'(m_e8));

    // Standalone clear.
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    m_e8 = '0;
    m_e2 = '0;
    check("clr_err8", 32'(err_count), 32'd0);
    check("clr_err2", 32'(err_count2), 32'd0);

    // Backpressure: frame held while toggling bits are offered.
    out_ready = 1'b0;
    send_frame(4'b0110, 1'b0, 0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bit   = i[0];
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h6);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_data_kept", 32'(out_data), 32'h6);
    send_frame(4'b1001, 1'b0, 0, 1'b0);
    idle(2);

    // Saturation of the 2-bit counter, then clear racing an increment.
    for (int unsigned k = 0; k < 4; k++) begin
      send_frame(4'b0011, 1'b1, 0, 1'b0);
      idle(2);
      check("sat_err2", 32'(err_count2), 32'(sat_exp[k]));
    end
    send_frame(4'b0011, 1'b1, 0, 1'b1);
    idle(2);
    check("sat_clr_err2", 32'(err_count2), 32'd0);
    check("sat_clr_err8", 32'(err_count), 32'd0);

    // Bad frame to make the counter nonzero, then reset mid-frame.
    send_frame(4'b0111, 1'b0, 0, 1'b0);
    idle(2);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    check("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_e8 = '0;
    m_e2 = '0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_ok", 32'(out_parity_ok), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    send_frame(4'b0110, 1'b0, 0, 1'b0);
    idle(3);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
